eth_rx_dispatch: RTL and testbench
==================================

// Module: eth_rx_dispatch
// PURPOSE
//  GMII receive-side dispatcher: the RX counterpart of the ARP/ICMP TX mux.
//  Parses each incoming frame (preamble/SFD, EtherType, IPv4 protocol) and
//  forwards it, delayed by DELAY cycles, to the ARP or ICMP receiver port only.
//  Other frames are dropped and counted. Sits between the GMII RX pins and
//  the arp_rx / icmp_rx receivers.
// PARAMETERS
//  DELAY      32                  pipeline depth in bytes; legal range >= 32
//  BOARD_MAC  48'h00_11_22_33_44_55  local MAC (used only with MAC_FILTER_EN)
// PORTS
//  clk              in   1   GMII RX clock (125 MHz)
//  rst_n            in   1   asynchronous reset, active low
//  gmii_rx_dv       in   1   GMII receive data valid
//  gmii_rxd         in   8   GMII receive data
//  arp_gmii_rx_dv   out  1   delayed dv, ARP frames only
//  arp_gmii_rxd     out  8   delayed data, ARP frames only (0 when gated)
//  icmp_gmii_rx_dv  out  1   delayed dv, ICMP frames only
//  icmp_gmii_rxd    out  8   delayed data, ICMP frames only (0 when gated)
//  frame_drop_cnt   out  16  count of dropped frames, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, pipeline cleared, class reg = DROP, state = DISCARD.
//  - Pipeline: DELAY-stage shift reg of {sof, dv, rxd}; sof=1 on first dv-high
//    cycle after dv low. Stage output registered; latency exactly DELAY cycles.
//  - FSM (byte index i counted from first dv-high byte, i=0):
//    DISCARD: wait dv=0 -> IDLE (protects against reset release mid-frame).
//    IDLE: dv=1 & rxd=8'h55 -> PREAMBLE; dv=1 & other byte -> DISCARD, drop.
//    PREAMBLE: 8'h55 stays; 8'hD5 at i in 1..7 -> HEADER (k=0); any other byte,
//      no SFD by i=7, or dv=0 -> drop (DISCARD or IDLE if dv=0).
//    HEADER: k = byte after SFD. k0-5 dest MAC, k12-13 EtherType, k23 IP proto.
//      k=13: type 16'h0806 -> class ARP, -> PAYLOAD; 16'h0800 -> continue;
//      else class DROP -> PAYLOAD. k=23: proto 8'h01 -> ICMP else DROP ->PAYLOAD.
//      dv=0 inside HEADER (runt) -> class DROP, -> IDLE.
//    PAYLOAD: wait dv=0 -> IDLE.
//  - Decision latched into pending-class reg at most 1 cycle after k=23 or dv
//    fall (i<=31), hence always before the frame's sof exits the pipeline.
//  - Output gate loaded from pending-class when delayed sof emerges; held until
//    delayed dv falls. Gate selects exactly one port or none; never both.
//  - frame_drop_cnt increments once per frame classed DROP (incl. bad preamble,
//    runt), on the decision cycle; no wrap past 16'hFFFF.
//  - Min IFG 12 bytes guarantees at most one pending decision; no queue needed.
//  - dv held low: all output dv low, rxd 0. Frame lengths unbounded in PAYLOAD.
//  - Reset mid-frame: outputs drop to 0 immediately; rest of frame discarded.
// CONFIGURATION
//  MAC_FILTER_EN defined: dest MAC (k0-5) must equal BOARD_MAC or
//    48'hFF_FF_FF_FF_FF_FF, else class DROP (counted) regardless of type.
//  MAC_FILTER_EN undefined: dest MAC ignored; BOARD_MAC unused; no compare logic.
// TESTING
//  1 ARP request (bcast, type 0806, 60B+preamble) -> identical bytes on arp_*
//    exactly 32 cycles later; icmp_* stay 0; frame_drop_cnt=0.
//  2 IPv4 proto 01 echo request -> bytes on icmp_* 32 cycles later; arp_* 0.
//  3 IPv4 proto 11 (UDP) frame -> both ports silent; frame_drop_cnt 0->1.
//  4 ARP frame then ICMP frame, 12-cycle IFG -> each on correct port, no byte
//    of either leaks to the other port; counter unchanged.
//  5 Runt: preamble+SFD+10 bytes, and frame with bad SFD (8'hD4) -> both
//    dropped, frame_drop_cnt +2; next valid ARP frame forwarded normally.
//  6 rst_n low at k=40 of ICMP frame, released while dv=1 -> outputs 0, tail
//    ignored; following ARP frame forwarded. With MAC_FILTER_EN, unicast to
//    48'h00_11_22_33_44_56 -> dropped, count +1.

Source files
------------

// File: rtl/eth_rx_dispatch.sv
// GMII RX dispatcher: classifies each frame as ARP, ICMP or drop and forwards it DELAY cycles later.
// Optional destination-MAC filtering is enabled by defining MAC_FILTER_EN.
module eth_rx_dispatch #(
    parameter int          DELAY     = 32,
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_gmii_rx_dv,
    output logic [7:0]  arp_gmii_rxd,
    output logic        icmp_gmii_rx_dv,
    output logic [7:0]  icmp_gmii_rxd,
    output logic [15:0] frame_drop_cnt
);

    typedef enum logic [2:0] {
        ST_DISCARD  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_HEADER   = 3'd3,
        ST_PAYLOAD  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_DROP = 2'd0,
        CLS_ARP  = 2'd1,
        CLS_ICMP = 2'd2
    } cls_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [7:0]  type_hi_q;
    logic [15:0] drop_cnt_q;
    logic        dv_prev_q;
    cls_t        pend_q;
    cls_t        gate_q;
    logic        arp_dv_q;
    logic [7:0]  arp_rxd_q;
    logic        icmp_dv_q;
    logic [7:0]  icmp_rxd_q;
    logic [9:0]  pipe_q [DELAY-1];

    logic        decide_s;
    cls_t        dec_cls_s;
    cls_t        pend_d;
    cls_t        gate_d;
    logic        sof_s;
    logic        mac_ok_s;
    logic        tail_sof_s;
    logic        tail_dv_s;
    logic [7:0]  tail_rxd_s;

`ifdef MAC_FILTER_EN
    logic [47:0] mac_q;

    assign mac_ok_s = (mac_q == BOARD_MAC) || (mac_q == 48'hFF_FF_FF_FF_FF_FF);

    // Collect the destination MAC while the header streams in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_q <= 48'h0;
        end else if (state_q == ST_HEADER && gmii_rx_dv && cnt_q < 5'd6) begin
            mac_q <= {mac_q[39:0], gmii_rxd};
        end
    end
`else
    logic board_mac_unused_s;

    assign mac_ok_s           = 1'b1;
    assign board_mac_unused_s = ^BOARD_MAC;
`endif

    assign sof_s = gmii_rx_dv && !dv_prev_q;

    // Classification decision for the byte currently on the pins; used same-cycle
    // so a decision on the last header byte still catches the frame's delayed sof.
    always_comb begin
        decide_s  = 1'b0;
        dec_cls_s = CLS_DROP;
        case (state_q)
            ST_IDLE: begin
                if (gmii_rx_dv && gmii_rxd != 8'h55) begin
                    decide_s = 1'b1;
                end else begin
                    decide_s = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    decide_s = 1'b1;
                end else if (gmii_rxd == 8'hD5) begin
                    decide_s = 1'b0;
                end else if (gmii_rxd == 8'h55 && cnt_q < 5'd7) begin
                    decide_s = 1'b0;
                end else begin
                    decide_s = 1'b1;
                end
            end
            ST_HEADER: begin
                if (!gmii_rx_dv) begin
                    decide_s = 1'b1;
                end else if (cnt_q == 5'd13) begin
                    if (!mac_ok_s || {type_hi_q, gmii_rxd} != 16'h0800) begin
                        decide_s  = 1'b1;
                        dec_cls_s = (mac_ok_s && {type_hi_q, gmii_rxd} == 16'h0806) ? CLS_ARP : CLS_DROP;
                    end else begin
                        decide_s = 1'b0;
                    end
                end else if (cnt_q == 5'd23) begin
                    decide_s  = 1'b1;
                    dec_cls_s = (gmii_rxd == 8'h01) ? CLS_ICMP : CLS_DROP;
                end else begin
                    decide_s = 1'b0;
                end
            end
            default: begin
                decide_s  = 1'b0;
                dec_cls_s = CLS_DROP;
            end
        endcase
    end

    // Frame parser state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DISCARD;
            cnt_q     <= 5'd0;
            type_hi_q <= 8'h00;
        end else begin
            case (state_q)
                ST_DISCARD: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55) begin
                            state_q <= ST_PREAMBLE;
                            cnt_q   <= 5'd1;
                        end else begin
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (gmii_rxd == 8'hD5) begin
                        state_q <= ST_HEADER;
                        cnt_q   <= 5'd0;
                    end else if (decide_s) begin
                        state_q <= ST_DISCARD;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_HEADER: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (cnt_q == 5'd12) begin
                            type_hi_q <= gmii_rxd;
                        end
                        if (decide_s) begin
                            state_q <= ST_PAYLOAD;
                        end
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_DISCARD;
                end
            endcase
        end
    end

    // Saturating count of frames classified as drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
        end else if (decide_s && dec_cls_s == CLS_DROP && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'h0001;
        end
    end

    // Delay line of {sof, dv, rxd}; the output registers supply the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_prev_q <= 1'b0;
            for (int i = 0; i < DELAY-1; i++) begin
                pipe_q[i] <= 10'h000;
            end
        end else begin
            dv_prev_q <= gmii_rx_dv;
            pipe_q[0] <= {sof_s, gmii_rx_dv, gmii_rxd};
            for (int i = 1; i < DELAY-1; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail_sof_s = pipe_q[DELAY-2][9];
    assign tail_dv_s  = pipe_q[DELAY-2][8];
    assign tail_rxd_s = pipe_q[DELAY-2][7:0];

    // Pending class follows the latest decision; the gate captures it at the delayed sof.
    always_comb begin
        pend_d = decide_s ? dec_cls_s : pend_q;
        if (tail_sof_s) begin
            gate_d = pend_d;
        end else if (tail_dv_s) begin
            gate_d = gate_q;
        end else begin
            gate_d = CLS_DROP;
        end
    end

    // Gated, registered output ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= CLS_DROP;
            gate_q     <= CLS_DROP;
            arp_dv_q   <= 1'b0;
            arp_rxd_q  <= 8'h00;
            icmp_dv_q  <= 1'b0;
            icmp_rxd_q <= 8'h00;
        end else begin
            pend_q     <= pend_d;
            gate_q     <= gate_d;
            arp_dv_q   <= tail_dv_s && (gate_d == CLS_ARP);
            arp_rxd_q  <= (tail_dv_s && gate_d == CLS_ARP) ? tail_rxd_s : 8'h00;
            icmp_dv_q  <= tail_dv_s && (gate_d == CLS_ICMP);
            icmp_rxd_q <= (tail_dv_s && gate_d == CLS_ICMP) ? tail_rxd_s : 8'h00;
        end
    end

    assign arp_gmii_rx_dv  = arp_dv_q;
    assign arp_gmii_rxd    = arp_rxd_q;
    assign icmp_gmii_rx_dv = icmp_dv_q;
    assign icmp_gmii_rxd   = icmp_rxd_q;
    assign frame_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: directed and random frames checked against a frame-level classifier model.
module tb_eth_rx_dispatch;

    localparam int          DLY   = 32;
    localparam int          EXPN  = 16384;
    localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h00_11_22_33_44_56;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_gmii_rx_dv;
    logic [7:0]  arp_gmii_rxd;
    logic        icmp_gmii_rx_dv;
    logic [7:0]  icmp_gmii_rxd;
    logic [15:0] frame_drop_cnt;

    eth_rx_dispatch #(.DELAY(DLY), .BOARD_MAC(BMAC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rxd        (gmii_rxd),
        .arp_gmii_rx_dv  (arp_gmii_rx_dv),
        .arp_gmii_rxd    (arp_gmii_rxd),
        .icmp_gmii_rx_dv (icmp_gmii_rx_dv),
        .icmp_gmii_rxd   (icmp_gmii_rxd),
        .frame_drop_cnt  (frame_drop_cnt)
    );

    always #4 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_drop = 0;
    logic [17:0] exp_out [EXPN];
    logic [7:0]  frm [$];

    // 0 = drop, 1 = ARP, 2 = ICMP, derived from the whole frame's bytes.
    function automatic int model_class(input logic [7:0] f [$]);
        int          sfd;
        int          h;
        logic [15:0] et;
`ifdef MAC_FILTER_EN
        logic [47:0] da;
`endif
        if (f.size() == 0 || f[0] != 8'h55) return 0;
        sfd = -1;
        for (int i = 1; i < f.size(); i++) begin
            if (f[i] == 8'hD5) begin
                sfd = i;
                break;
            end
            if (f[i] != 8'h55 || i >= 7) return 0;
        end
        if (sfd < 0) return 0;
        h = sfd + 1;
        if (f.size() < h + 14) return 0;
`ifdef MAC_FILTER_EN
        da = {f[h], f[h+1], f[h+2], f[h+3], f[h+4], f[h+5]};
        if (da != BMAC && da != BCAST) return 0;
`endif
        et = {f[h+12], f[h+13]};
        if (et == 16'h0806) return 1;
        if (et != 16'h0800) return 0;
        if (f.size() < h + 24) return 0;
        return (f[h+23] == 8'h01) ? 2 : 0;
    endfunction

    task automatic mk(input int npre, input logic [7:0] sfd, input logic [47:0] dst,
                      input logic [15:0] et, input logic [7:0] pr, input int nbody);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(sfd);
        for (int k = 0; k < nbody; k++) begin
            b = 8'($urandom);
            if (k < 6)        b = dst[8*(5-k) +: 8];
            else if (k == 12) b = et[15:8];
            else if (k == 13) b = et[7:0];
            else if (k == 23) b = pr;
            frm.push_back(b);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input int cls);
        logic [17:0] obs;
        @(negedge clk);
        cyc++;
        obs = {arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd};
        n_assert++;
        assert (obs === exp_out[cyc]) else begin
            n_fail++;
            $error("FAIL out_bytes cyc=%0d observed=%h expected=%h", cyc, obs, exp_out[cyc]);
        end
        gmii_rx_dv = v;
        gmii_rxd   = d;
        if (cyc + DLY < EXPN) begin
            if (v && cls == 1)      exp_out[cyc+DLY] = {1'b1, d, 9'h000};
            else if (v && cls == 2) exp_out[cyc+DLY] = {9'h000, 1'b1, d};
            else                    exp_out[cyc+DLY] = 18'h0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 0);
    endtask

    task automatic check_cnt(input string tag);
        n_assert++;
        assert (frame_drop_cnt === 16'(exp_drop)) else begin
            n_fail++;
            $error("FAIL %s: drop_cnt observed=%0d expected=%0d", tag, frame_drop_cnt, exp_drop);
        end
    endtask

    task automatic send(input int ifg, input string tag);
        int cls;
        cls = model_class(frm);
        if (cls == 0 && exp_drop < 65535) exp_drop++;
        for (int i = 0; i < frm.size(); i++) tick(1'b1, frm[i], cls);
        idle(ifg);
        check_cnt(tag);
    endtask

    initial begin
        int          kind;
        int          r;
        logic [47:0] dst;
        int          blen;

        for (int i = 0; i < EXPN; i++) exp_out[i] = 18'h0;
        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        idle(4);
        check_cnt("reset_cnt");
        rst_n = 1'b1;
        idle(4);

        mk(7, 8'hD5, BCAST, 16'h0806, 8'h00, 60);
        send(12, "arp_bcast");
        mk(7, 8'hD5, BMAC, 16'h0800, 8'h01, 74);
        send(12, "icmp_echo");
        mk(7, 8'hD5, BMAC, 16'h0800, 8'h11, 74);
        send(12, "udp_drop");
        mk(7, 8'hD5, BCAST, 16'h0806, 8'h00, 60);
        send(12, "arp_then");
        mk(7, 8'hD5, BMAC, 16'h0800, 8'h01, 64);
        send(12, "icmp_after");
        mk(7, 8'hD5, BCAST, 16'h0800, 8'h01, 10);
        send(12, "runt");
        mk(7, 8'hD4, BCAST, 16'h0806, 8'h00, 60);
        send(12, "bad_sfd");
        mk(7, 8'hD5, BCAST, 16'h0806, 8'h00, 60);
        send(12, "arp_after_drop");

        // Reset asserted at header byte 40 of an ICMP frame, released while dv is high.
        mk(7, 8'hD5, BMAC, 16'h0800, 8'h01, 80);
        for (int i = 0; i < 48; i++) tick(1'b1, frm[i], 2);
        rst_n = 1'b0;
        for (int c = cyc + 1; c <= cyc + DLY + 1 && c < EXPN; c++) exp_out[c] = 18'h0;
        exp_drop = 0;
        #1;
        n_assert++;
        assert ({arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd} === 18'h0) else begin
            n_fail++;
            $error("FAIL rst_async: observed=%h expected=0",
                   {arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd});
        end
        check_cnt("rst_cnt");
        for (int i = 48; i < 52; i++) tick(1'b1, frm[i], 0);
        rst_n = 1'b1;
        for (int i = 52; i < frm.size(); i++) tick(1'b1, frm[i], 0);
        idle(12);
        check_cnt("rst_tail");
        mk(7, 8'hD5, BCAST, 16'h0806, 8'h00, 60);
        send(12, "arp_after_rst");
        mk(7, 8'hD5, OTHER, 16'h0806, 8'h00, 60);
        send(12, "unicast_other");

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 7);
            r    = $urandom_range(0, 2);
            dst  = (r == 0) ? BCAST : ((r == 1) ? BMAC : OTHER);
            blen = $urandom_range(46, 100);
            case (kind)
                0: mk(7, 8'hD5, dst, 16'h0806, 8'($urandom), blen);
                1: mk(7, 8'hD5, dst, 16'h0800, 8'h01, blen);
                2: mk(7, 8'hD5, dst, 16'h0800, 8'($urandom_range(2, 255)), blen);
                3: mk(7, 8'hD5, dst, 16'($urandom_range(0, 16'h07FF)), 8'h01, blen);
                4: mk(7, 8'hD5, dst, 16'h0800, 8'h01, $urandom_range(0, 23));
                5: mk(7, 8'($urandom_range(0, 8'hD4)), dst, 16'h0806, 8'h00, blen);
                6: mk($urandom_range(1, 7), 8'hD5, dst, ($urandom_range(0, 1) == 0) ? 16'h0806 : 16'h0800, 8'h01, blen);
                default: mk(8, 8'hD5, dst, 16'h0806, 8'h00, blen);
            endcase
            send($urandom_range(12, 20), "random");
        end
        idle(40);
        check_cnt("final_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
